// File: rtl/sort3_pkg.sv
// rtl/sort3_pkg.sv - shared state enum and index codes for the three-operand sorter
package sort3_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SORT1 = 3'd1,
        SORT2 = 3'd2,
        SORT3 = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] IDX_A    = 2'b00;
    localparam logic [1:0] IDX_B    = 2'b01;
    localparam logic [1:0] IDX_C    = 2'b10;
    localparam logic [1:0] CODE_TIE = 2'b11;

endpackage

// File: rtl/sort3_16bit_seq_cmp_swap.sv
// rtl/sort3_16bit_seq_cmp_swap.sv - combinational compare-swap of two value/index pairs
module cmp_swap #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x_val,
    input  logic [1:0]       x_idx,
    input  logic [WIDTH-1:0] y_val,
    input  logic [1:0]       y_idx,
    output logic [WIDTH-1:0] first_val,
    output logic [1:0]       first_idx,
    output logic [WIDTH-1:0] second_val,
    output logic [1:0]       second_idx
);

    logic swap;

    // Strict compare keeps the original order on ties
    assign swap       = (x_val < y_val);
    assign first_val  = swap ? y_val : x_val;
    assign first_idx  = swap ? y_idx : x_idx;
    assign second_val = swap ? x_val : y_val;
    assign second_idx = swap ? x_idx : y_idx;

endmodule

// File: rtl/sort3_16bit_seq.sv
// rtl/sort3_16bit_seq.sv - sequential three-operand descending sorter with tie codes
module sort3_16bit_seq
    import sort3_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] mid_val,
    output logic [WIDTH-1:0] min_val,
    output logic [1:0]       max_idx,
    output logic [1:0]       mid_idx,
    output logic [1:0]       min_idx,
    output logic [1:0]       largest,
    output logic [1:0]       smallest,
    output logic             all_equal
);

    state_t state, state_next;

    logic [WIDTH-1:0] s0_val, s1_val, s2_val;
    logic [1:0]       s0_idx, s1_idx, s2_idx;

    logic [WIDTH-1:0] x_val, y_val, f_val, g_val;
    logic [1:0]       x_idx, y_idx, f_idx, g_idx;

    // The single compare-swap sees (s1,s2) in SORT2 and (s0,s1) otherwise
    always_comb begin
        x_val = s0_val;
        x_idx = s0_idx;
        y_val = s1_val;
        y_idx = s1_idx;
        if (state == SORT2) begin
            x_val = s1_val;
            x_idx = s1_idx;
            y_val = s2_val;
            y_idx = s2_idx;
        end
    end

    cmp_swap #(.WIDTH(WIDTH)) u_cmp_swap (
        .x_val      (x_val),
        .x_idx      (x_idx),
        .y_val      (y_val),
        .y_idx      (y_idx),
        .first_val  (f_val),
        .first_idx  (f_idx),
        .second_val (g_val),
        .second_idx (g_idx)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_next = SORT1;
            SORT1:   state_next = SORT2;
            SORT2:   state_next = SORT3;
            SORT3:   state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_val    <= '0;
            s1_val    <= '0;
            s2_val    <= '0;
            s0_idx    <= '0;
            s1_idx    <= '0;
            s2_idx    <= '0;
            max_val   <= '0;
            mid_val   <= '0;
            min_val   <= '0;
            max_idx   <= '0;
            mid_idx   <= '0;
            min_idx   <= '0;
            largest   <= '0;
            smallest  <= '0;
            all_equal <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    s0_val <= a;
                    s0_idx <= IDX_A;
                    s1_val <= b;
                    s1_idx <= IDX_B;
                    s2_val <= c;
                    s2_idx <= IDX_C;
                end
                SORT1: begin
                    s0_val <= f_val;
                    s0_idx <= f_idx;
                    s1_val <= g_val;
                    s1_idx <= g_idx;
                end
                SORT2: begin
                    s1_val <= f_val;
                    s1_idx <= f_idx;
                    s2_val <= g_val;
                    s2_idx <= g_idx;
                end
                SORT3: begin
                    // Final swap result goes straight into the output registers
                    s0_val    <= f_val;
                    s0_idx    <= f_idx;
                    s1_val    <= g_val;
                    s1_idx    <= g_idx;
                    max_val   <= f_val;
                    max_idx   <= f_idx;
                    mid_val   <= g_val;
                    mid_idx   <= g_idx;
                    min_val   <= s2_val;
                    min_idx   <= s2_idx;
                    largest   <= (f_val == g_val) ? CODE_TIE : f_idx;
                    smallest  <= (g_val == s2_val) ? CODE_TIE : s2_idx;
                    all_equal <= (f_val == s2_val);
                end
                default: ;
            endcase
        end
    end

endmodule
